// File: rtl/mprj_io_ctrl_pkg.sv
// Shared constants and types for the user-project pad control block.
package mprj_io_ctrl_pkg;
    localparam int CFG_W       = 5;
    localparam int OEB_BIT     = 0;
    localparam int INP_DIS_BIT = 1;
    localparam int DM_LSB      = 2;
    localparam int RD_W        = 8;

    localparam logic [2:0]       DM_DEFAULT = 3'b001;
    // Input-only pad: dm=001, input enabled, output disabled
    localparam logic [CFG_W-1:0] CFG_RESET  = {DM_DEFAULT, 1'b0, 1'b1};

    typedef enum logic [1:0] {
        SEL_CFG = 2'd0,
        SEL_OUT = 2'd1,
        SEL_CLR = 2'd2
    } cfg_sel_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISABLE = 2'd1,
        MODE    = 2'd2,
        ENABLE  = 2'd3
    } state_e;
endpackage

// File: rtl/mprj_io_ctrl_if.sv
// Config-write, commit and readback bus of the pad control block.
interface mprj_io_ctrl_if
    import mprj_io_ctrl_pkg::*;
#(
    parameter int ADDR_W = 6
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_sel;
    logic [ADDR_W-1:0] cfg_addr;
    logic [CFG_W-1:0]  cfg_wdata;
    logic              commit_req;
    logic              commit_busy;
    logic [ADDR_W-1:0] rd_addr;
    logic [RD_W-1:0]   rd_data;

    modport master (
        output cfg_valid, cfg_sel, cfg_addr, cfg_wdata, commit_req, rd_addr,
        input  cfg_ready, commit_busy, rd_data
    );

    modport slave (
        input  cfg_valid, cfg_sel, cfg_addr, cfg_wdata, commit_req, rd_addr,
        output cfg_ready, commit_busy, rd_data
    );
endinterface

// File: rtl/mprj_io_ctrl_in_sync.sv
// One pad input: 2-flop synchroniser plus sticky rising-edge flag with W1C clear.
module mprj_io_in_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic clr,
    output logic sync,
    output logic rise
);
    logic s1, s2, rise_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1     <= d;
            s2     <= s1;
            // A new edge wins over a clear landing in the same cycle
            rise_q <= (s1 & ~s2) | (rise_q & ~clr);
        end
    end

    assign sync = s2;
    assign rise = rise_q;
endmodule

// File: rtl/mprj_io_ctrl.sv
// Pad config shadow/active registers, glitch-safe commit sequencer and input flags.
module mprj_io_ctrl
    import mprj_io_ctrl_pkg::*;
#(
    parameter int TOTAL_PADS = 38,
    parameter int SETTLE_CYC = 4,
    parameter int ADDR_W     = 6
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    mprj_io_ctrl_if.slave           bus,
    output logic [TOTAL_PADS-1:0]   io_out,
    output logic [TOTAL_PADS-1:0]   oeb,
    output logic [TOTAL_PADS-1:0]   inp_dis,
    output logic [3*TOTAL_PADS-1:0] dm,
    input  logic [TOTAL_PADS-1:0]   io_in,
    output logic [TOTAL_PADS-1:0]   io_in_sync,
    output logic [TOTAL_PADS-1:0]   io_rise
);
    localparam int                CNT_W      = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [ADDR_W:0]   NPADS      = (ADDR_W + 1)'(TOTAL_PADS);

    logic [TOTAL_PADS-1:0][CFG_W-1:0] shadow_q, shadow_d, active_q;
    logic [TOTAL_PADS-1:0]            mask_q, mask_d, out_q, out_d, rise_clr;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [RD_W-1:0]                  rd_q, rd_d;
    state_e                           state_q, state_d;
    logic                             wr_ok, hold;

    assign bus.cfg_ready   = (state_q == IDLE);
    assign bus.commit_busy = (state_q != IDLE);
    assign bus.rd_data     = rd_q;
    assign wr_ok = bus.cfg_valid && bus.cfg_ready && ({1'b0, bus.cfg_addr} < NPADS);

    always_comb begin
        shadow_d = shadow_q;
        out_d    = out_q;
        rise_clr = '0;
        if (wr_ok) begin
            case (bus.cfg_sel)
                SEL_CFG: shadow_d[bus.cfg_addr] = bus.cfg_wdata;
                SEL_OUT: out_d[bus.cfg_addr]    = bus.cfg_wdata[0];
                SEL_CLR: rise_clr[bus.cfg_addr] = bus.cfg_wdata[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: if (bus.commit_req) begin
                state_d = DISABLE;
                cnt_d   = CNT_RELOAD;
                // shadow_d so that a write accepted alongside the commit is included
                for (int i = 0; i < TOTAL_PADS; i++)
                    mask_d[i] = (shadow_d[i] != active_q[i]);
            end
            DISABLE: if (cnt_q == '0) begin
                state_d = MODE;
                cnt_d   = CNT_RELOAD;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            MODE: if (cnt_q == '0) state_d = ENABLE;
                  else             cnt_d   = cnt_q - 1'b1;
            ENABLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_d = '0;
        if ({1'b0, bus.rd_addr} < NPADS)
            rd_d = {io_rise[bus.rd_addr], io_in_sync[bus.rd_addr],
                    out_q[bus.rd_addr], active_q[bus.rd_addr]};
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mask_q   <= '0;
            shadow_q <= {TOTAL_PADS{CFG_RESET}};
            active_q <= {TOTAL_PADS{CFG_RESET}};
            out_q    <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            rd_q     <= rd_d;
            // dm/inp_dis land at the end of DISABLE, oeb only at the end of MODE
            for (int i = 0; i < TOTAL_PADS; i++) begin
                if (mask_q[i] && state_q == DISABLE && cnt_q == '0)
                    active_q[i][CFG_W-1:INP_DIS_BIT] <= shadow_q[i][CFG_W-1:INP_DIS_BIT];
                if (mask_q[i] && state_q == MODE && cnt_q == '0)
                    active_q[i][OEB_BIT] <= shadow_q[i][OEB_BIT];
            end
        end
    end

    assign hold   = (state_q == DISABLE) || (state_q == MODE);
    assign io_out = out_q;

    for (genvar i = 0; i < TOTAL_PADS; i++) begin : g_pad
        assign oeb[i]         = active_q[i][OEB_BIT] | (mask_q[i] & hold);
        assign inp_dis[i]     = active_q[i][INP_DIS_BIT];
        assign dm[3*i +: 3]   = active_q[i][DM_LSB +: 3];

        mprj_io_in_sync u_sync (
            .clk  (wb_clk_i),
            .rst  (wb_rst_i),
            .d    (io_in[i]),
            .clr  (rise_clr[i]),
            .sync (io_in_sync[i]),
            .rise (io_rise[i])
        );
    end
endmodule

// File: tb/tb_mprj_io_ctrl.sv
// Directed bench: stimulus queues expected pad/bus values by cycle; a monitor compares them.
module tb_mprj_io_ctrl;
    import mprj_io_ctrl_pkg::*;

    localparam int NP = 38;
    localparam int SC = 4;
    localparam int AW = 6;

    localparam int K_OEB = 0, K_OEBV = 1, K_DM = 2, K_DMV = 3, K_INP = 4, K_INPV = 5,
                   K_OUTV = 6, K_SYNC = 7, K_RISE = 8, K_READY = 9, K_BUSY = 10, K_RD = 11;

    typedef struct {
        int           cyc;
        int           kind;
        int           idx;
        logic [127:0] val;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mprj_io_ctrl_if #(.ADDR_W(AW)) bus();
    logic [NP-1:0]   io_out, oeb, inp_dis, io_in, io_in_sync, io_rise;
    logic [3*NP-1:0] dm;

    mprj_io_ctrl #(.TOTAL_PADS(NP), .SETTLE_CYC(SC), .ADDR_W(AW)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .bus        (bus),
        .io_out     (io_out),
        .oeb        (oeb),
        .inp_dis    (inp_dis),
        .dm         (dm),
        .io_in      (io_in),
        .io_in_sync (io_in_sync),
        .io_rise    (io_rise)
    );

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_at(int c, int k, int i, logic [127:0] v, string nm);
        exp_t e;
        int   p;
        e.cyc = c; e.kind = k; e.idx = i; e.val = v; e.name = nm;
        p = q.size();
        for (int j = 0; j < q.size(); j++) begin
            if (q[j].cyc > c) begin
                p = j;
                break;
            end
        end
        q.insert(p, e);
    endfunction

    function automatic logic [127:0] sample(int k, int i);
        case (k)
            K_OEB:   return 128'(oeb[i]);
            K_OEBV:  return 128'(oeb);
            K_DM:    return 128'(dm[3*i +: 3]);
            K_DMV:   return 128'(dm);
            K_INP:   return 128'(inp_dis[i]);
            K_INPV:  return 128'(inp_dis);
            K_OUTV:  return 128'(io_out);
            K_SYNC:  return 128'(io_in_sync[i]);
            K_RISE:  return 128'(io_rise[i]);
            K_READY: return 128'(bus.cfg_ready);
            K_BUSY:  return 128'(bus.commit_busy);
            K_RD:    return 128'(bus.rd_data);
            default: return '1;
        endcase
    endfunction

    exp_t         m_e;
    logic [127:0] m_a;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m_e = q.pop_front();
            m_a = sample(m_e.kind, m_e.idx);
            checks++;
            if (m_e.cyc != cyc || m_a !== m_e.val) begin
                errors++;
                $display("FAIL %s @cyc%0d: got %0h expected %0h", m_e.name, m_e.cyc, m_a, m_e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [AW-1:0] addr, input logic [4:0] data);
        bus.cfg_valid = 1'b1;
        bus.cfg_sel   = sel;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    logic [NP-1:0]   ones, ov;
    logic [3*NP-1:0] dm_def, dv;
    int n, e;

    initial begin
        ones = '1;
        for (int i = 0; i < NP; i++) dm_def[3*i +: 3] = 3'b001;
        bus.cfg_valid = 1'b0; bus.cfg_sel = '0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        bus.commit_req = 1'b0; bus.rd_addr = '0;
        io_in = '0;

        // Reset defaults
        tick(); tick();
        expect_at(cyc, K_OEBV, 0, 128'(ones), "rst_oeb");
        expect_at(cyc, K_INPV, 0, 128'(0), "rst_inp_dis");
        expect_at(cyc, K_DMV, 0, 128'(dm_def), "rst_dm");
        expect_at(cyc, K_OUTV, 0, 128'(0), "rst_io_out");
        expect_at(cyc, K_READY, 0, 128'(1), "rst_ready");
        expect_at(cyc, K_BUSY, 0, 128'(0), "rst_busy");
        expect_at(cyc, K_RD, 0, 128'(0), "rst_rd");
        rst = 1'b0;
        tick();

        // Pad 5 -> dm 110, drive enabled, through a full commit
        wr(SEL_CFG, 6'd5, 5'b110_0_0);
        n = cyc;
        expect_at(n, K_OEB, 5, 128'(1), "shadow_only_oeb5");
        bus.commit_req = 1'b1;
        for (int k = 1; k <= 8; k++) expect_at(n + k, K_OEB, 5, 128'(1), "commit_oeb5_held");
        expect_at(n + 9, K_OEB, 5, 128'(0), "commit_oeb5_final");
        expect_at(n + 4, K_DM, 5, 128'(3'b001), "commit_dm5_old");
        expect_at(n + 5, K_DM, 5, 128'(3'b110), "commit_dm5_new");
        for (int k = 1; k <= 9; k++) expect_at(n + k, K_READY, 0, 128'(0), "commit_ready_low");
        expect_at(n + 10, K_READY, 0, 128'(1), "commit_ready_back");
        expect_at(n + 1, K_BUSY, 0, 128'(1), "commit_busy_first");
        expect_at(n + 9, K_BUSY, 0, 128'(1), "commit_busy_last");
        expect_at(n + 10, K_BUSY, 0, 128'(0), "commit_busy_done");
        ov = ones; ov[5] = 1'b0;
        dv = dm_def; dv[17:15] = 3'b110;
        expect_at(n + 9, K_OEBV, 0, 128'(ov), "commit_oeb_others");
        expect_at(n + 9, K_DMV, 0, 128'(dv), "commit_dm_others");
        tick();
        bus.commit_req = 1'b0;
        repeat (9) tick();

        // Output data writes, in and out of range
        e = cyc;
        expect_at(e, K_OUTV, 0, 128'(0), "out_before");
        expect_at(e + 1, K_OUTV, 0, 128'(38'(1) << 37), "out_pad37");
        wr(SEL_OUT, 6'd37, 5'b00001);
        expect_at(e + 2, K_OUTV, 0, 128'(38'(1) << 37), "out_addr40_ignored");
        expect_at(e + 2, K_OEBV, 0, 128'(ov), "out_addr40_oeb");
        wr(SEL_OUT, 6'd40, 5'b00001);

        // Input sync, rise flag, W1C and set-beats-clear
        e = cyc;
        io_in[3] = 1'b1;
        expect_at(e + 1, K_SYNC, 3, 128'(0), "sync3_stage1");
        expect_at(e + 2, K_SYNC, 3, 128'(1), "sync3_stage2");
        expect_at(e + 1, K_RISE, 3, 128'(0), "rise3_early");
        expect_at(e + 2, K_RISE, 3, 128'(1), "rise3_set");
        expect_at(e + 2, K_RISE, 4, 128'(0), "rise4_quiet");
        tick(); tick();
        expect_at(cyc + 1, K_RISE, 3, 128'(0), "rise3_w1c");
        expect_at(cyc + 1, K_SYNC, 3, 128'(1), "sync3_hold");
        wr(SEL_CLR, 6'd3, 5'b00001);
        io_in[3] = 1'b0;
        expect_at(cyc + 3, K_RISE, 3, 128'(0), "rise3_no_fall");
        repeat (3) tick();
        e = cyc;
        io_in[3] = 1'b1;
        expect_at(e + 2, K_RISE, 3, 128'(1), "rise3_set_beats_clr");
        expect_at(e + 3, K_RISE, 3, 128'(1), "rise3_sticky");
        tick();
        wr(SEL_CLR, 6'd3, 5'b00001);
        tick();

        // Readback
        bus.rd_addr = 6'd5;  expect_at(cyc + 1, K_RD, 0, 128'(8'h18), "rd_pad5");  tick();
        bus.rd_addr = 6'd50; expect_at(cyc + 1, K_RD, 0, 128'(8'h00), "rd_oor");   tick();
        bus.rd_addr = 6'd3;  expect_at(cyc + 1, K_RD, 0, 128'(8'hC5), "rd_pad3");  tick();
        bus.rd_addr = 6'd37; expect_at(cyc + 1, K_RD, 0, 128'(8'h25), "rd_pad37"); tick();

        // Write + commit in the same cycle, then a commit while busy
        n = cyc;
        bus.cfg_valid = 1'b1; bus.cfg_sel = SEL_CFG; bus.cfg_addr = 6'd10; bus.cfg_wdata = 5'b010_1_0;
        bus.commit_req = 1'b1;
        expect_at(n + 4, K_INP, 10, 128'(0), "wc_inp10_old");
        expect_at(n + 5, K_INP, 10, 128'(1), "wc_inp10_new");
        expect_at(n + 5, K_DM, 10, 128'(3'b010), "wc_dm10");
        expect_at(n + 8, K_OEB, 10, 128'(1), "wc_oeb10_held");
        expect_at(n + 9, K_OEB, 10, 128'(0), "wc_oeb10_final");
        expect_at(n + 9, K_READY, 0, 128'(0), "busy_commit_ready9");
        expect_at(n + 10, K_READY, 0, 128'(1), "busy_commit_ready10");
        expect_at(n + 11, K_BUSY, 0, 128'(0), "busy_commit_ignored");
        tick();
        bus.cfg_valid = 1'b0; bus.commit_req = 1'b0;
        tick(); tick();
        bus.commit_req = 1'b1;
        tick();
        bus.commit_req = 1'b0;
        repeat (7) tick();

        // Reset while in MODE
        wr(SEL_CFG, 6'd10, 5'b100_0_1);
        n = cyc;
        bus.commit_req = 1'b1;
        expect_at(n + 5, K_DM, 10, 128'(3'b100), "midrst_dm10_mode");
        expect_at(n + 5, K_OEB, 10, 128'(1), "midrst_oeb10_forced");
        expect_at(n + 6, K_OEBV, 0, 128'(ones), "midrst_oeb");
        expect_at(n + 6, K_DMV, 0, 128'(dm_def), "midrst_dm");
        expect_at(n + 6, K_INPV, 0, 128'(0), "midrst_inp_dis");
        expect_at(n + 6, K_OUTV, 0, 128'(0), "midrst_io_out");
        expect_at(n + 6, K_BUSY, 0, 128'(0), "midrst_busy");
        expect_at(n + 6, K_SYNC, 3, 128'(0), "midrst_sync3");
        expect_at(n + 7, K_READY, 0, 128'(1), "midrst_ready");
        tick();
        bus.commit_req = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Commit with nothing changed leaves pads alone
        n = cyc;
        bus.commit_req = 1'b1;
        expect_at(n + 1, K_BUSY, 0, 128'(1), "nochg_busy");
        expect_at(n + 5, K_OEBV, 0, 128'(ones), "nochg_oeb_mid");
        expect_at(n + 9, K_OEBV, 0, 128'(ones), "nochg_oeb");
        expect_at(n + 9, K_DMV, 0, 128'(dm_def), "nochg_dm");
        expect_at(n + 10, K_READY, 0, 128'(1), "nochg_ready");
        tick();
        bus.commit_req = 1'b0;

        for (int k = 0; k < 100 && q.size() > 0; k++) tick();
        if (q.size() > 0) begin
            $display("FAIL drain: got %0d pending expected 0", q.size());
            errors += q.size();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
